// File: rtl/gram_wb_bist.sv
// Wishbone classic master that writes a generated pattern over a word range,
// reads it back in order and reports mismatches, timeouts and busy cycles.
module gram_wb_bist #(
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERR_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              cfg_mode,
  input  logic [ADDR_WIDTH-1:0]   cfg_base,
  input  logic [LEN_WIDTH-1:0]    cfg_length,
  input  logic [DATA_WIDTH-1:0]   cfg_seed,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH-1:0]   wb_dat_w,
  input  logic [DATA_WIDTH-1:0]   wb_dat_r,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  input  logic                    wb_ack,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [ERR_WIDTH-1:0]    err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_adr,
  output logic [DATA_WIDTH-1:0]   first_err_exp,
  output logic [DATA_WIDTH-1:0]   first_err_got,
  output logic [31:0]             cycles
);

  localparam int          WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int          POS_W     = $clog2(DATA_WIDTH);
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_BUS, S_WR_GAP, S_RD_BUS, S_RD_GAP, S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            mode_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [DATA_WIDTH-1:0] seed_r;
  logic [LEN_WIDTH-1:0]  index;
  logic [POS_W-1:0]      walk_pos;
  logic [31:0]           lfsr;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [DATA_WIDTH-1:0] pattern;
  logic                  last_word;
  logic                  wait_expired;
  logic                  bus_active;

  function automatic logic [31:0] lfsr_init(input logic [DATA_WIDTH-1:0] s);
    logic [31:0] low;
    low = 32'(s);
    return (low == 32'd0) ? 32'd1 : low;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  assign last_word    = (index == len_r - LEN_WIDTH'(1));
  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    pattern = '0;
    case (mode_r)
      2'd1:    for (int i = 0; i < DATA_WIDTH; i++) pattern[i] = lfsr[i % 32];
      2'd2:    pattern = (DATA_WIDTH'(1) << walk_pos) ^ seed_r;
      default: pattern = DATA_WIDTH'(index) ^ seed_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE:
        if (start) state_nxt = (cfg_length == '0) ? S_DONE : S_WR_BUS;
      S_WR_BUS:
        if (wb_ack)            state_nxt = S_WR_GAP;
        else if (wait_expired) state_nxt = S_DONE;
      S_WR_GAP: state_nxt = last_word ? S_RD_BUS : S_WR_BUS;
      S_RD_BUS:
        if (wb_ack)            state_nxt = S_RD_GAP;
        else if (wait_expired) state_nxt = S_DONE;
      S_RD_GAP: state_nxt = last_word ? S_DONE : S_RD_BUS;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus_active = (state == S_WR_BUS) || (state == S_RD_BUS);
    wb_cyc     = bus_active;
    wb_stb     = bus_active;
    wb_we      = (state == S_WR_BUS);
    wb_sel     = bus_active ? '1 : '0;
    wb_adr     = bus_active ? base_r + ADDR_WIDTH'(index) : '0;
    wb_dat_w   = (state == S_WR_BUS) ? pattern : '0;
    busy       = bus_active || (state == S_WR_GAP) || (state == S_RD_GAP);
    done       = (state == S_DONE);
    pass       = done && (err_count == '0) && !timeout;
  end

  // Config latches, generator, wait counter and result registers.
  always_ff @(posedge clk) begin
    // NOTE: the datapath is reset along with the FSM so every result output
    // reads 0 straight out of reset rather than stale values.
    if (!rst_n) begin
      mode_r        <= '0;
      base_r        <= '0;
      len_r         <= '0;
      seed_r        <= '0;
      index         <= '0;
      walk_pos      <= '0;
      lfsr          <= '0;
      wait_cnt      <= '0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_adr <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
      cycles        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (busy && cycles != '1) cycles <= cycles + 32'd1;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          mode_r        <= cfg_mode;
          base_r        <= cfg_base;
          len_r         <= cfg_length;
          seed_r        <= cfg_seed;
          index         <= '0;
          walk_pos      <= '0;
          lfsr          <= lfsr_init(cfg_seed);
          wait_cnt      <= '0;
          timeout       <= 1'b0;
          err_count     <= '0;
          first_err_adr <= '0;
          first_err_exp <= '0;
          first_err_got <= '0;
          cycles        <= '0;
        end
        S_WR_BUS, S_RD_BUS: begin
          if (wb_ack) begin
            if (state == S_RD_BUS && wb_dat_r != pattern) begin
              if (err_count != '1) err_count <= err_count + ERR_WIDTH'(1);
              if (err_count == '0) begin
                first_err_adr <= wb_adr;
                first_err_exp <= pattern;
                first_err_got <= wb_dat_r;
              end
            end
          end else if (wait_expired) begin
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WR_GAP, S_RD_GAP: begin
          wait_cnt <= '0;
          if (last_word) begin
            index    <= '0;
            walk_pos <= '0;
            lfsr     <= lfsr_init(seed_r);
          end else begin
            index    <= index + LEN_WIDTH'(1);
            walk_pos <= (walk_pos == POS_W'(DATA_WIDTH - 1)) ? '0 : walk_pos + POS_W'(1);
            lfsr     <= lfsr_step(lfsr);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
